// File: rtl/bcd_clock_timer_if.sv
// ----------------------------------------------------------------------------
// bcd_clock_timer_if
// Bundles the control, load and time/event signals of bcd_clock_timer.
//   enable, count_up, load        : run/pause, direction, one-cycle load strobe
//   load_hh, load_mm, load_ss     : BCD load values {tens, ones}
//   hh, mm, ss                    : current time, BCD {tens, ones}
//   tick_sec, wrap, done, load_err: one-cycle event pulses
// master: the controlling side (drives controls, observes time and events)
// slave : the timer itself
// ----------------------------------------------------------------------------
interface bcd_clock_timer_if;
   logic       enable;
   logic       count_up;
   logic       load;
   logic [7:0] load_hh;
   logic [7:0] load_mm;
   logic [7:0] load_ss;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       tick_sec;
   logic       wrap;
   logic       done;
   logic       load_err;

   modport master (
      output enable, count_up, load, load_hh, load_mm, load_ss,
      input  hh, mm, ss, tick_sec, wrap, done, load_err
   );

   modport slave (
      input  enable, count_up, load, load_hh, load_mm, load_ss,
      output hh, mm, ss, tick_sec, wrap, done, load_err
   );
endinterface

// File: rtl/bcd_clock_timer.sv
// ----------------------------------------------------------------------------
// bcd_clock_timer
// Real-time clock / countdown timer. A prescaler derives a one-cycle second
// event from clk; each event advances a cascaded hh:mm:ss BCD counter up or
// down. Loads are range-checked and rejected loads raise load_err.
//
// Parameters:
//   CLK_HZ   : system clock frequency, prescaler divisor (>= 2)
//   HOUR_MOD : hour modulus, 1..99
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset, clears all state
//   bus      : bcd_clock_timer_if.slave (controls, load values, time, pulses)
// Build option:
//   CLOCK_FAST_SIM_EN : when defined the prescaler divisor is 10 regardless of
//                       CLK_HZ (simulation only; never define for synthesis)
// ----------------------------------------------------------------------------
module bcd_clock_timer #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int HOUR_MOD = 24
) (
   input  logic              clk,
   input  logic              reset_n,
   bcd_clock_timer_if.slave  bus
);

`ifdef CLOCK_FAST_SIM_EN
   localparam int DIV = 10;
`else
   localparam int DIV = CLK_HZ;
`endif
   localparam int             PW     = $clog2(DIV);
   localparam logic [PW-1:0]  TC     = PW'(DIV - 1);
   localparam logic [7:0]     HH_MAX = {4'((HOUR_MOD - 1) / 10), 4'((HOUR_MOD - 1) % 10)};

   logic [PW-1:0] presc_q;
   logic [7:0]    hh_q, mm_q, ss_q;
   logic          tick_q, wrap_q, done_q, err_q;

   logic [7:0]    hh_n, mm_n, ss_n;
   logic          wrap_n, done_n;
   logic          is_zero;
   logic          load_ok;
   logic [7:0]    load_hh_dec;

   // Single-digit BCD step helpers; callers handle the wrap at the field limit.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
   endfunction

   // Next time value for a second event. Down-counting holds at 00:00:00, so
   // the hour borrow can only happen while hh is non-zero.
   always_comb begin
      hh_n    = hh_q;
      mm_n    = mm_q;
      ss_n    = ss_q;
      wrap_n  = 1'b0;
      done_n  = 1'b0;
      is_zero = (hh_q == 8'h00) && (mm_q == 8'h00) && (ss_q == 8'h00);
      if (bus.count_up) begin
         if (ss_q == 8'h59) begin
            ss_n = 8'h00;
            if (mm_q == 8'h59) begin
               mm_n = 8'h00;
               if (hh_q == HH_MAX) begin
                  hh_n   = 8'h00;
                  wrap_n = 1'b1;
               end else begin
                  hh_n = bcd_inc(hh_q);
               end
            end else begin
               mm_n = bcd_inc(mm_q);
            end
         end else begin
            ss_n = bcd_inc(ss_q);
         end
      end else if (!is_zero) begin
         if (ss_q == 8'h00) begin
            ss_n = 8'h59;
            if (mm_q == 8'h00) begin
               mm_n = 8'h59;
               hh_n = bcd_dec(hh_q);
            end else begin
               mm_n = bcd_dec(mm_q);
            end
         end else begin
            ss_n = bcd_dec(ss_q);
         end
         done_n = (hh_q == 8'h00) && (mm_q == 8'h00) && (ss_q == 8'h01);
      end
   end

   // Load range check: every digit decimal, minutes/seconds tens at most 5,
   // hours below HOUR_MOD when read as a decimal number.
   always_comb begin
      load_hh_dec = {4'd0, bus.load_hh[7:4]} * 8'd10 + {4'd0, bus.load_hh[3:0]};
      load_ok     = (bus.load_hh[3:0] <= 4'd9) && (bus.load_hh[7:4] <= 4'd9) &&
                    (bus.load_mm[3:0] <= 4'd9) && (bus.load_mm[7:4] <= 4'd5) &&
                    (bus.load_ss[3:0] <= 4'd9) && (bus.load_ss[7:4] <= 4'd5) &&
                    (int'(load_hh_dec) < HOUR_MOD);
   end

   // Prescaler, time registers and event pulses. A load takes priority over a
   // coinciding terminal count, so that second event is dropped entirely.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         hh_q    <= 8'h00;
         mm_q    <= 8'h00;
         ss_q    <= 8'h00;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (bus.load) begin
            if (load_ok) begin
               hh_q    <= bus.load_hh;
               mm_q    <= bus.load_mm;
               ss_q    <= bus.load_ss;
               presc_q <= '0;
            end else begin
               err_q <= 1'b1;
            end
         end else if (bus.enable) begin
            if (presc_q == TC) begin
               presc_q <= '0;
               tick_q  <= 1'b1;
               wrap_q  <= wrap_n;
               done_q  <= done_n;
               hh_q    <= hh_n;
               mm_q    <= mm_n;
               ss_q    <= ss_n;
            end else begin
               presc_q <= presc_q + 1'b1;
            end
         end
      end
   end

   assign bus.hh       = hh_q;
   assign bus.mm       = mm_q;
   assign bus.ss       = ss_q;
   assign bus.tick_sec = tick_q;
   assign bus.wrap     = wrap_q;
   assign bus.done     = done_q;
   assign bus.load_err = err_q;

endmodule
